iterative_shifter: RTL and testbench
====================================

// Module: iterative_shifter
// PURPOSE
// - Multi-cycle, parametrised shift unit for the execute stage; replaces fixed-distance combinational shift stages.
// - Resolves one binary-weighted stage per clock (1,2,4,...,WIDTH/2) on a single registered accumulator.
// - Supports SLL, SRL, SRA and ROL under one start/ready handshake.
// - Completion is signalled by a one-cycle result_valid pulse for the pipeline stall logic.
// PARAMETERS
// - WIDTH   32   operand/result width; power of two, >= 4
// - SHAMT_W (localparam) = $clog2(WIDTH); shift-amount width and stage count (5 at default)
// PORTS
// - clock         in   1        rising-edge clock
// - reset         in   1        asynchronous, active-high reset
// - start         in   1        request; sampled only when ready=1
// - mode          in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL
// - x             in   WIDTH    operand
// - shamt         in   SHAMT_W  shift amount (unsigned)
// - ready         out  1        unit can accept start this cycle
// - result        out  WIDTH    shifted value; held until next accept
// - result_zero   out  1        result == 0
// - result_valid  out  1        one-cycle pulse: result is new
// BEHAVIOUR
// - Reset (async): state=IDLE, acc=0, stage cnt=0, result_valid=0. Then ready=1, result=0, result_zero=1.
// - States: IDLE, SHIFT, DONE. ready = (state!=SHIFT).
// - Accept: start && ready at edge t.
//   - Latch mode, shamt; acc<=x; cnt<=0; state<=SHIFT.
//   - Applies in IDLE and in DONE (back-to-back accept is permitted).
// - SHIFT, each edge: if shamt_q[cnt], acc <= acc shifted by 2^cnt per mode_q; else acc unchanged.
//   - cnt<=cnt+1; on cnt==SHAMT_W-1, state<=DONE and result_valid<=1.
// - Fixed latency: SHIFT occupies edges t+1..t+SHAMT_W; result_valid is high for the cycle after edge t+SHAMT_W.
//   - No early-out; shamt=0 takes the full SHAMT_W cycles.
// - DONE lasts one cycle: result_valid=1 there only.
//   - Next edge goes to SHIFT (new accept) or IDLE; result_valid<=0.
// - Shift rules:
//   - SLL: zero fill.
//   - SRL: zero fill.
//   - SRA: fill with acc[WIDTH-1]; sign preserved every stage.
//   - ROL: bits shifted out at the MSB re-enter at the LSB.
// - result = acc. result_zero = ~|acc. Both are combinational from acc.
//   - result shows intermediate values during SHIFT; it is valid only with result_valid.
// - start while ready=0 is ignored and not queued; inputs x, shamt and mode may change freely during SHIFT.
// - Reset mid-operation aborts immediately, with no result_valid pulse.
//   - The first start after reset deassertion is accepted normally.
// - start asserted in the same cycle as reset deassertion is sampled at the next edge.
// TESTING (WIDTH=32)
// - SLL x=0x00000001 shamt=8 -> result_valid exactly 5 cycles after accept; result=0x00000100, result_zero=0.
// - SRA vs SRL, x=0x80000000 shamt=4:
//   - SRA -> 0xF8000000.
//   - SRL -> 0x08000000.
// - ROL x=0x80000001 shamt=1 -> 0x00000003.
// - ROL x=0xDEADBEEF shamt=31 -> 0xEF56DF77.
// - shamt=0, x=0x12345678 -> 0x12345678 after 5 cycles.
// - SLL x=0xFFFFFFFF shamt=31 -> 0x80000000.
// - SRL x=0x1 shamt=1 -> 0x0 with result_zero=1.
// - Busy start ignored: start pulsed 2 cycles after accept with other operands -> only the first result returns; one pulse.
// - Back-to-back start in the DONE cycle -> second result_valid 5 cycles later; no gap state.
// - reset asserted 3 cycles into SHIFT -> immediately ready=1, result=0, no result_valid.
//   - A new SLL 0x3 by 2 then returns 0xC.

Source files
------------

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL unit: one binary-weighted stage per clock on a registered accumulator.
// Fixed latency of SHAMT_W cycles after accept; ready low while shifting, start ignored (not queued) when busy.
module iterative_shifter #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic [WIDTH-1:0]   result,
  output logic               result_zero,
  output logic               result_valid
);

  localparam int CNT_W = $clog2(SHAMT_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SHAMT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         mode_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               valid_q;
  logic [SHAMT_W-1:0] step, rstep;

  // Stage cnt moves by 2^cnt; rstep = WIDTH - step, modulo WIDTH, for the rotate wrap.
  always_comb begin
    step  = SHAMT_W'(1) << cnt_q;
    rstep = SHAMT_W'(0) - step;
    acc_d = acc_q;
    if (shamt_q[cnt_q]) begin
      case (mode_q)
        2'b00:   acc_d = acc_q << step;
        2'b01:   acc_d = acc_q >> step;
        2'b10:   acc_d = $unsigned($signed(acc_q) >>> step);
        default: acc_d = (acc_q << step) | (acc_q >> rstep);
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept, so a new op can start in the DONE cycle.
          valid_q <= 1'b0;
          if (start) begin
            mode_q  <= mode;
            shamt_q <= shamt;
            acc_q   <= x;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign ready        = (state_q != SHIFT);
  assign result       = acc_q;
  assign result_zero  = ~|acc_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: stimulus pushes reference results, a negedge monitor pops on result_valid.
module tb_iterative_shifter;
  localparam int W = 32;
  localparam int SW = 5;
  localparam time PER = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  x;
  logic [SW-1:0] shamt;
  logic          ready;
  logic [W-1:0]  result;
  logic          result_zero;
  logic          result_valid;

  iterative_shifter #(.WIDTH(W)) dut (
    .clock(clk), .reset(rst), .start(start), .mode(mode), .x(x), .shamt(shamt),
    .ready(ready), .result(result), .result_zero(result_zero), .result_valid(result_valid)
  );

  always #(PER/2) clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    time          t_acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int expected_pulses = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: one whole-distance shift, straight from the operation definitions.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input logic [W-1:0] v, input logic [SW-1:0] s);
    logic signed [W-1:0] sv;
    logic [2*W-1:0]      dbl;
    sv  = v;
    dbl = {v, v} << s;
    case (m)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return sv >>> s;
      default: return dbl[2*W-1:W];
    endcase
  endfunction

  // b2b: wait for result_valid instead of ready so the accept lands in the DONE cycle.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] v, input logic [SW-1:0] s, input bit b2b);
    int n = 0;
    @(negedge clk);
    while ((b2b ? !result_valid : !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (b2b ? !result_valid : !ready) begin
      check("issue_timeout", 64'd1, 64'd0);
      return;
    end
    start = 1'b1; mode = m; x = v; shamt = s;
    @(posedge clk);
    sb.push_back('{ref_shift(m, v, s), $time});
    expected_pulses++;
    #1;
    start = 1'b0; mode = 2'($urandom); x = $urandom; shamt = 5'($urandom);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && result_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("result_zero", 64'(result_zero), 64'(e.res == '0));
          check("latency", 64'($time - e.t_acc), 64'(SW * PER + PER / 2));
        end
      end
    end
  end

  initial begin : stim
    int n;
    rst = 1'b1; start = 1'b0; mode = 2'b00; x = '0; shamt = '0;
    #(PER + 2);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(result_zero), 64'd1);
    check("rst_valid", 64'(result_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(2'b00, 32'h0000_0001, 5'd8, 0);
    issue(2'b10, 32'h8000_0000, 5'd4, 0);
    issue(2'b01, 32'h8000_0000, 5'd4, 0);
    issue(2'b11, 32'h8000_0001, 5'd1, 0);
    issue(2'b11, 32'hDEAD_BEEF, 5'd31, 0);
    issue(2'b00, 32'h1234_5678, 5'd0, 0);
    issue(2'b00, 32'hFFFF_FFFF, 5'd31, 0);
    issue(2'b01, 32'h0000_0001, 5'd1, 0);

    // Busy start: pulse a different op two cycles into SHIFT; it must be dropped.
    issue(2'b01, 32'hF0F0_0000, 5'd12, 0);
    @(negedge clk);
    check("busy_ready", 64'(ready), 64'd0);
    start = 1'b1; mode = 2'b00; x = 32'h1111_1111; shamt = 5'd3;
    @(negedge clk);
    start = 1'b0;

    // Back-to-back accepts in the DONE cycle.
    issue(2'b10, 32'h8765_4321, 5'd9, 1);
    issue(2'b11, 32'h0F00_00F0, 5'd20, 1);

    // Reset three cycles into SHIFT aborts with no pulse.
    issue(2'b00, 32'hABCD_0123, 5'd7, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    expected_pulses--;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero", 64'(result_zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b00, 32'h0000_0003, 5'd2, 0);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), $urandom, 5'($urandom), ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    check("pulse_count", 64'(pulses), 64'(expected_pulses));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
